// File: rtl/key_pkg.sv
// Shared defaults and types for the key-input front end.
package key_pkg;
  localparam int NUM_KEYS_DEFAULT    = 17;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int DEBOUNCE_DEFAULT    = 16;

  typedef logic [NUM_KEYS_DEFAULT-1:0] keys_t;
endpackage

// File: rtl/key_debounce.sv
// One key channel: accepts a level change after DEBOUNCE_CYCLES consecutive differing
// samples and emits a registered one-cycle press or release pulse with the change.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic en_i,
  input  logic sample_i,
  output logic stable_o,
  output logic press_o,
  output logic release_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (!en_i || (sample_i == stable_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // The accept rule caps the count, so it can never wrap.
      stable_d  = sample_i;
      cnt_d     = '0;
      press_d   = sample_i;
      release_d = ~sample_i;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign stable_o  = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;
endmodule

// File: rtl/key_conditioner.sv
// Key-pad front end: synchroniser chain, per-channel debounce with edge pulses, and a
// lowest-index priority encoder over the debounced levels.
module key_conditioner
  import key_pkg::*;
#(
  parameter int  NUM_KEYS        = NUM_KEYS_DEFAULT,
  parameter int  SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int  DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  localparam int IDX_W           = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NUM_KEYS-1:0] async_keys,
  input  logic                en,
  output logic [NUM_KEYS-1:0] keys_stable,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic                any_key,
  output logic [IDX_W-1:0]    key_index
);
  // Pure flop chain: nothing may sit between stages or metastability settling suffers.
  logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] sync_q;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge nrst) begin
          if (!nrst) sync_q[gi] <= '0;
          else       sync_q[gi] <= async_keys;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge nrst) begin
          if (!nrst) sync_q[gi] <= '0;
          else       sync_q[gi] <= sync_q[gi-1];
        end
      end
    end

    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk      (clk),
        .nrst     (nrst),
        .en_i     (en),
        .sample_i (sync_q[SYNC_STAGES-1][gi]),
        .stable_o (keys_stable[gi]),
        .press_o  (press_pulse[gi]),
        .release_o(release_pulse[gi])
      );
    end
  endgenerate

  assign any_key = |keys_stable;

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    key_index = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys_stable[i]) key_index = IDX_W'(i);
    end
  end
endmodule
